vis_ctrl: RTL



---
 rtl/vis_pkg.sv | 29 ++
 rtl/bin2bcd_seq.sv | 81 ++++++++
 rtl/vis_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vis_pkg.sv
// Shared definitions for the display-value front end: mode codes, converter
// states and the decimal-width helper used to size-check the digit count.
package vis_pkg;

  localparam logic [1:0] VIS_HEX  = 2'd0;
  localparam logic [1:0] VIS_DEC  = 2'd1;
  localparam logic [1:0] VIS_HOLD = 2'd2;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_LOAD  = 2'd1,
    CV_SHIFT = 2'd2,
    CV_DONE  = 2'd3
  } cv_state_e;

  // Number of decimal digits needed to show 2^bin_w - 1.
  function automatic int bcd_digits(input int bin_w);
    logic [63:0] max_val;
    int          n;
    max_val = (64'd1 << bin_w) - 64'd1;
    n = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: LOAD samples the input, SHIFT runs IN_W
// add-3/shift steps, DONE presents the result for one cycle, then repeats.
module bin2bcd_seq
  import vis_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  cv_state_e         state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [DW-1:0]     bcd_q, bcd_d;
  logic [DW-1:0]     bcd_adj;
  logic [CW-1:0]     cnt_q, cnt_d;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      CV_IDLE: begin
        if (start) state_d = CV_LOAD;
      end
      CV_LOAD: begin
        bin_d   = bin_in;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = CV_SHIFT;
      end
      CV_SHIFT: begin
        bcd_d = {bcd_adj[DW-2:0], bin_q[IN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(IN_W - 1)) state_d = CV_DONE;
      end
      CV_DONE: begin
        state_d = CV_LOAD;
      end
      default: state_d = CV_IDLE;
    endcase
    // Abort wins over everything so a mode change stops the engine next cycle.
    if (abort) state_d = CV_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == CV_LOAD) || (state_q == CV_SHIFT);
  assign done    = (state_q == CV_DONE);
  assign bcd_out = bcd_q;

endmodule

// File: rtl/vis_ctrl.sv
// Display-value front end: button sync/debounce, HEX/DEC/HOLD mode cycling,
// output registers. Optional leading-zero blanking under VIS_BLANK_EN.
module vis_ctrl
  import vis_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 4,
  parameter int DEB_MS = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce1ms,
  input  logic [IN_W-1:0]       sw,
  input  logic                  btn,
  output logic [4*DIGITS-1:0]   dat,
  output logic [1:0]            mode,
  output logic                  busy,
  output logic [DIGITS-1:0]     blank
);

  localparam int DW  = 4 * DIGITS;
  localparam int DBW = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;

  if (bcd_digits(IN_W) > DIGITS) begin : g_size_check
    $fatal(1, "vis_ctrl: DIGITS too small for the BCD of 2^IN_W-1");
  end
  if (DEB_MS < 1) begin : g_deb_check
    $fatal(1, "vis_ctrl: DEB_MS must be at least 1");
  end

  logic             btn_s1_q, btn_s2_q;
  logic             deb_q, deb_d, deb_prev_q;
  logic [DBW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [DW-1:0]    dat_q, dat_d;
  logic             cv_busy, cv_done;
  logic [DW-1:0]    cv_bcd;

  bin2bcd_seq #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mode_q == VIS_DEC),
    .abort   (mode_q != VIS_DEC),
    .bin_in  (sw),
    .busy    (cv_busy),
    .done    (cv_done),
    .bcd_out (cv_bcd)
  );

  // Counter only runs while the synchronised and debounced levels disagree.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    if (btn_s2_q == deb_q) begin
      deb_cnt_d = '0;
    end else if (ce1ms) begin
      if (deb_cnt_q == DBW'(DEB_MS - 1)) begin
        deb_d     = ~deb_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (deb_q && !deb_prev_q) begin
      case (mode_q)
        VIS_HEX: mode_d = VIS_DEC;
        VIS_DEC: mode_d = VIS_HOLD;
        default: mode_d = VIS_HEX;
      endcase
    end
  end

  always_comb begin
    dat_d = dat_q;
    case (mode_q)
      VIS_HEX: dat_d = DW'(sw);
      VIS_DEC: if (cv_done) dat_d = cv_bcd;
      default: dat_d = dat_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      mode_q     <= VIS_HEX;
      dat_q      <= '0;
    end else begin
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      mode_q     <= mode_d;
      dat_q      <= dat_d;
    end
  end

  assign dat  = dat_q;
  assign mode = mode_q;
  assign busy = cv_busy;

`ifdef VIS_BLANK_EN
  // Mask follows dat_d, so it freezes in HOLD exactly when dat does.
  logic [DIGITS-1:0] blank_d, blank_q;

  assign blank_d[0] = 1'b0;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
    assign blank_d[gi] = ~|dat_d[DW-1:4*gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= '0;
    else        blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule
